gelu_rr_scheduler: RTL and testbench
====================================

# gelu_rr_scheduler

Round-robin scheduler that shares one registered activation unit (gelu_lut or gelu_piecewise) among NREQ requesters. Each requester streams signed 8-bit operands over a valid/ready handshake. The block issues at most one operand per cycle to the unit and tags each issue with the requester ID through a shift pipeline. Each result returns to its requester with the matching ID. It sits between the per-lane datapaths and the single shared activation instance.

## Interface
- NREQ, 4: number of requesters, 2..8.
- W, 8: operand and result width, signed.
- LAT, 1: cycles from the unit sampling x_in to y_out being valid. The existing gelu units are 1.
- BURST, 4: maximum consecutive beats a requester keeps the grant, 1..15.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  NREQ  per-requester operand valid.
- req_x  in  NREQ*W  operands, requester i at bits [i*W +: W].
- req_ready  out  NREQ  one-hot-or-zero grant; a beat transfers when req_valid[i] & req_ready[i].
- act_x  out  W  registered operand to the unit's x_in.
- act_y  in  W  unit's y_out.
- rsp_valid  out  NREQ  one-hot-or-zero result strobe.
- rsp_y  out  W  result, shared by all requesters.
- rsp_id  out  clog2(NREQ)  ID of the current result.
- busy  out  1  high while any issued beat is still in the tag pipeline.

## Operation
- State registers:
  - owner (ID)
  - locked (1 bit)
  - cnt (4 bits)
  - tag pipeline of 1+LAT stages, each {valid, id}
  - act_x
- Grant, combinational:
  - If locked & req_valid[owner] & cnt<BURST, grant owner.
  - Otherwise grant the first i with req_valid[i], searching (owner+1) mod NREQ upward with wrap.
  - No valid requester means no grant.
- req_ready[g] is asserted only for the granted g. req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
- On a handshake by g:
  - act_x <= req_x[g].
  - Tag stage 0 <= {1, g}.
  - If g==owner and locked, cnt <= cnt+1. Otherwise owner <= g, cnt <= 1.
  - locked <= 1.
- On no handshake:
  - act_x <= 0 (bubble).
  - Tag stage 0 <= {0, 0}.
  - locked <= 0, so the next grant rotates.
- Lock release:
  - A granted owner that drops req_valid loses the lock.
  - Reaching cnt==BURST forces rotation to the next valid requester, even if the owner is still valid.
  - A lone requester at cnt==BURST is re-granted by the search; cnt restarts at 1 and there is no bubble.
- The tag pipeline shifts every cycle. There is no stall and no response backpressure: requesters must accept rsp_valid unconditionally.
- Result path, combinational from the last tag stage:
  - rsp_valid[id] = tag valid.
  - rsp_y = act_y when tag valid, else 0.
  - rsp_id = id.
- busy = OR of all tag valid bits.
- Results return in issue order. The block never reorders.

## Timing
- Reset (asynchronous, immediate):
  - act_x, rsp_y, rsp_id = 0.
  - rsp_valid, req_ready = 0.
  - busy = 0.
  - owner=0, locked=0, cnt=0, all tags invalid.
  - req_ready stays 0 while reset is high.
- Latency: a handshake in cycle t puts the operand on act_x in cycle t+1. rsp_valid/rsp_y appear in cycle t+1+LAT, which is cycle t+2 at the default.
- Throughput: 1 beat/cycle sustained across requesters, including across grant switches (no dead cycle on rotation).
- Fairness: with all NREQ requesters continuously valid, grants run in the sequence 0×BURST, 1×BURST, …, (NREQ−1)×BURST, then repeat.
- Reset mid-operation: in-flight tags are discarded, and the results never appear. After reset is released, arbitration restarts from owner 0, searching from ID 1.
- A requester dropping req_valid in the same cycle the lock would expire: the grant goes to the next valid requester, and cnt restarts.

## Test plan
- Single requester 0 streams x=-128..127 back-to-back.
  - Required: 256 rsp_valid[0] pulses, each 2 cycles after its beat.
  - Required: rsp_y equals the standalone unit's output for the same x.
  - Required: rsp_id=0 throughout.
- Requesters 0 and 1 both continuously valid, BURST=4.
  - Required: req_ready pattern 0,0,0,0,1,1,1,1,0,… with no idle cycle.
  - Required: rsp_id follows the same pattern delayed by 2.
- All 4 requesters valid, each sending its ID as x.
  - Required: every response carries rsp_y = unit(ID) and rsp_id=ID.
  - Required: over 64 cycles, each requester receives exactly 16 grants.
- Requester 2 drops req_valid after 2 beats while requester 3 is valid.
  - Required: the grant moves to 3 the next cycle.
  - Required: 2's later re-request waits for 3's burst to end.
- Assert reset 1 cycle after an issue.
  - Required: rsp_valid stays 0 and busy=0 immediately.
  - Required: after release, a first beat from requester 1 returns after 2 cycles with the correct value.
- No requests for 10 cycles.
  - Required: act_x=0, busy=0, all rsp_valid=0.
  - Required: the next single beat returns at t+2.

Source files
------------

// File: rtl/gelu_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : gelu_rr_scheduler
//  Purpose  : Round-robin scheduler sharing one registered activation unit
//             among NREQ requesters. At most one operand is issued per cycle.
//             Each issue carries a requester ID through a tag pipeline that
//             matches the unit latency, so every result returns to its
//             requester in issue order.
//  Ports    : clk, reset (async, active-high)
//             req_valid/req_ready/req_x : per-requester operand handshake
//             act_x / act_y             : shared activation unit x_in / y_out
//             rsp_valid/rsp_y/rsp_id    : result strobe, value and ID
//             busy                      : any issued beat still in flight
//  Revision : 1.0 - initial release
// ============================================================================
module gelu_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int W     = 8,
    parameter int LAT   = 1,
    parameter int BURST = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*W-1:0]         req_x,
    output logic [NREQ-1:0]           req_ready,
    output logic [W-1:0]              act_x,
    input  logic [W-1:0]              act_y,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [W-1:0]              rsp_y,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic                      busy
);

    localparam int IDW = $clog2(NREQ);

    // Arbitration state
    logic [IDW-1:0] r_owner;
    logic           r_locked;
    logic [3:0]     r_cnt;
    logic [W-1:0]   r_act_x;

    // Tag pipeline: stage 0 lines up with act_x, stage LAT with act_y
    logic [LAT:0]   r_tag_v;
    logic [IDW-1:0] r_tag_id [0:LAT];

    logic           w_hold;
    logic           w_srch_found;
    logic [IDW-1:0] w_srch_id;
    logic           w_fire;
    logic [IDW-1:0] w_gnt_id;
    logic [W-1:0]   w_gnt_x;

    // Rotating search starting one past the owner. Iterating from the far
    // end downwards lets the nearest valid requester win the last write.
    // The final offset (NREQ) lands on the owner itself, which is what
    // re-grants a lone requester whose burst has expired.
    always_comb begin : p_search
        int idx;
        idx          = 0;
        w_srch_found = 1'b0;
        w_srch_id    = '0;
        for (int off = NREQ; off >= 1; off--) begin
            idx = (int'(r_owner) + off) % NREQ;
            if (req_valid[idx]) begin
                w_srch_found = 1'b1;
                w_srch_id    = IDW'(idx);
            end
        end
    end

    // Owner keeps the grant only while it stays valid and its burst is open.
    assign w_hold   = r_locked & req_valid[r_owner] & (r_cnt < 4'(BURST));
    // Any grant goes to a valid requester, so a grant is always a handshake.
    assign w_fire   = (w_hold | w_srch_found) & ~reset;
    assign w_gnt_id = w_hold ? r_owner : w_srch_id;
    assign w_gnt_x  = req_x[int'(w_gnt_id)*W +: W];

    always_comb begin : p_ready
        req_ready = '0;
        if (w_fire) begin
            req_ready[w_gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin : p_state
        if (reset) begin
            r_owner  <= '0;
            r_locked <= 1'b0;
            r_cnt    <= '0;
            r_act_x  <= '0;
            r_tag_v  <= '0;
            for (int i = 0; i <= LAT; i++) begin
                r_tag_id[i] <= '0;
            end
        end else begin
            r_tag_v     <= {r_tag_v[LAT-1:0], w_fire};
            r_tag_id[0] <= w_fire ? w_gnt_id : '0;
            for (int i = 1; i <= LAT; i++) begin
                r_tag_id[i] <= r_tag_id[i-1];
            end

            if (w_fire) begin
                r_act_x  <= w_gnt_x;
                r_locked <= 1'b1;
                if (w_hold) begin
                    r_cnt <= r_cnt + 4'd1;
                end else begin
                    // New owner, or a lone requester re-granted after its
                    // burst expired: the burst count restarts either way.
                    r_owner <= w_gnt_id;
                    r_cnt   <= 4'd1;
                end
            end else begin
                r_act_x  <= '0;
                r_locked <= 1'b0;
            end
        end
    end

    // Result path straight off the last tag stage
    assign act_x  = r_act_x;
    assign rsp_id = r_tag_id[LAT];
    assign rsp_y  = r_tag_v[LAT] ? act_y : '0;
    assign busy   = |r_tag_v;

    always_comb begin : p_rsp
        rsp_valid = '0;
        if (r_tag_v[LAT]) begin
            rsp_valid[r_tag_id[LAT]] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gelu_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gelu_rr_scheduler
//  Purpose  : Self-checking bench for gelu_rr_scheduler. A registered
//             stand-in activation unit closes the loop; a grant model
//             predicts req_ready every cycle and queues expected responses,
//             and an independent monitor pops them when they fall due.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gelu_rr_scheduler;

    localparam int NREQ  = 4;
    localparam int W     = 8;
    localparam int LAT   = 1;
    localparam int BURST = 4;

    logic                 clk       = 1'b0;
    logic                 reset     = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*W-1:0]    req_x     = '0;
    logic [NREQ-1:0]      req_ready;
    logic [W-1:0]         act_x;
    logic [W-1:0]         act_y     = '0;
    logic [NREQ-1:0]      rsp_valid;
    logic [W-1:0]         rsp_y;
    logic [1:0]           rsp_id;
    logic                 busy;

    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;

    gelu_rr_scheduler #(
        .NREQ (NREQ),
        .W    (W),
        .LAT  (LAT),
        .BURST(BURST)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_x    (req_x),
        .req_ready(req_ready),
        .act_x    (act_x),
        .act_y    (act_y),
        .rsp_valid(rsp_valid),
        .rsp_y    (rsp_y),
        .rsp_id   (rsp_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in activation: identity for x>=0, x/4 (arith) for x<0
    function automatic logic [W-1:0] unit_fn(input logic [W-1:0] x);
        logic signed [W-1:0] s;
        s = x;
        if (s >= 0) return x;
        return s >>> 2;
    endfunction

    always @(posedge clk) act_y <= unit_fn(act_x);

    // ---------------- reference model ----------------
    typedef struct {
        int           due;
        int           id;
        logic [W-1:0] y;
    } exp_t;

    exp_t         sb[$];
    int           m_owner  = 0;
    int           m_run    = 0;
    bit           m_locked = 1'b0;
    logic [W-1:0] m_act    = '0;

    function automatic int model_grant(input logic [NREQ-1:0] v);
        if (m_locked && v[m_owner] && m_run < BURST) return m_owner;
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(m_owner + k) % NREQ]) return (m_owner + k) % NREQ;
        end
        return -1;
    endfunction

    // One cycle of stimulus; returns the model's grant (-1 for none)
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] x,
                        output int g);
        logic [NREQ-1:0] exp_rdy;
        exp_t            e;
        @(negedge clk);
        #2;
        req_valid = v;
        req_x     = x;
        #1;
        nvec++;
        if (act_x !== m_act) begin
            nfail++;
            $display("FAIL act_x cyc=%0d: got %h want %h", cyc, act_x, m_act);
        end
        g = model_grant(v);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        nvec++;
        if (req_ready !== exp_rdy) begin
            nfail++;
            $display("FAIL req_ready cyc=%0d valid=%b: got %b want %b",
                     cyc, v, req_ready, exp_rdy);
        end
        if (g >= 0) begin
            e.due = cyc + 1 + 1 + (LAT - 1) + 0;
            e.due = cyc + 1 + LAT;
            e.id  = g;
            e.y   = unit_fn(x[g*W +: W]);
            sb.push_back(e);
            if (m_locked && g == m_owner && m_run < BURST) begin
                m_run++;
            end else begin
                m_owner = g;
                m_run   = 1;
            end
            m_locked = 1'b1;
            m_act    = x[g*W +: W];
        end else begin
            m_locked = 1'b0;
            m_act    = '0;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #2;
        reset     = 1'b1;
        req_valid = '1;
        sb.delete();
        #1;
        nvec++;
        if (busy !== 1'b0 || rsp_valid !== '0 || req_ready !== '0 ||
            act_x !== '0 || rsp_y !== '0 || rsp_id !== '0) begin
            nfail++;
            $display("FAIL reset_state: busy=%b rsp_valid=%b ready=%b act_x=%h rsp_y=%h id=%0d want all 0",
                     busy, rsp_valid, req_ready, act_x, rsp_y, rsp_id);
        end
        repeat (n) begin
            @(negedge clk);
            #3;
            nvec++;
            if (req_ready !== '0) begin
                nfail++;
                $display("FAIL ready_in_reset: got %b want 0", req_ready);
            end
        end
        @(negedge clk);
        #2;
        reset     = 1'b0;
        req_valid = '0;
        m_owner   = 0;
        m_run     = 0;
        m_locked  = 1'b0;
        m_act     = '0;
    endtask

    function automatic logic [NREQ*W-1:0] rand_x();
        logic [NREQ*W-1:0] r;
        for (int i = 0; i < NREQ; i++) r[i*W +: W] = W'($urandom);
        return r;
    endfunction

    // ---------------- monitor ----------------
    initial begin : p_monitor
        exp_t            e;
        logic            busy_exp;
        logic [NREQ-1:0] vexp;
        forever begin
            @(negedge clk);
            if (reset) begin
                nvec++;
                if (rsp_valid !== '0 || busy !== 1'b0) begin
                    nfail++;
                    $display("FAIL rsp_in_reset: rsp_valid=%b busy=%b want 0/0", rsp_valid, busy);
                end
            end else begin
                busy_exp = (sb.size() > 0) && (sb[0].due <= cyc + LAT);
                nvec++;
                if (busy !== busy_exp) begin
                    nfail++;
                    $display("FAIL busy cyc=%0d: got %b want %b", cyc, busy, busy_exp);
                end
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    vexp = '0;
                    vexp[e.id] = 1'b1;
                    nvec++;
                    if (rsp_valid !== vexp || rsp_id !== 2'(e.id) || rsp_y !== e.y) begin
                        nfail++;
                        $display("FAIL rsp cyc=%0d: got valid=%b id=%0d y=%h want valid=%b id=%0d y=%h",
                                 cyc, rsp_valid, rsp_id, rsp_y, vexp, e.id, e.y);
                    end
                end else begin
                    nvec++;
                    if (rsp_valid !== '0 || rsp_y !== '0) begin
                        nfail++;
                        $display("FAIL spurious_rsp cyc=%0d: got valid=%b y=%h want none",
                                 cyc, rsp_valid, rsp_y);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : p_stim
        int                g;
        int                val;
        int                sent;
        int                gcnt[NREQ];
        logic [NREQ*W-1:0] xx;
        logic [NREQ-1:0]   v;

        do_reset(3);

        // Requester 0 streams -128..127 back-to-back
        val  = -128;
        sent = 0;
        for (int s = 0; s < 300 && sent < 256; s++) begin
            xx = '0;
            xx[W-1:0] = W'(val);
            step(4'b0001, xx, g);
            if (g == 0) begin
                val++;
                sent++;
            end
        end

        // Requesters 0 and 1 continuously valid
        step('0, '0, g);
        for (int s = 0; s < 24; s++) step(4'b0011, rand_x(), g);

        // All requesters valid, each sending its own ID
        step('0, '0, g);
        for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
        xx = '0;
        for (int i = 0; i < NREQ; i++) xx[i*W +: W] = W'(i);
        for (int s = 0; s < 64; s++) begin
            step(4'b1111, xx, g);
            if (g >= 0) gcnt[g]++;
        end
        for (int i = 0; i < NREQ; i++) begin
            nvec++;
            if (gcnt[i] != 16) begin
                nfail++;
                $display("FAIL fairness req%0d: got %0d grants want 16", i, gcnt[i]);
            end
        end

        // Requester 2 drops after 2 beats while 3 is valid, then re-requests
        step('0, '0, g);
        step(4'b0100, rand_x(), g);
        step(4'b1100, rand_x(), g);
        step(4'b1000, rand_x(), g);
        for (int s = 0; s < 6; s++) step(4'b1100, rand_x(), g);

        // Reset one cycle after an issue, then a fresh beat from requester 1
        step('0, '0, g);
        step(4'b0010, rand_x(), g);
        do_reset(2);
        step(4'b0010, rand_x(), g);

        // Idle for 10 cycles, then one beat
        for (int s = 0; s < 10; s++) step('0, '0, g);
        step(4'b0100, rand_x(), g);

        // Randomized traffic
        for (int s = 0; s < 400; s++) begin
            v = ($urandom_range(0, 3) == 0) ? 4'hF : NREQ'($urandom_range(0, 15));
            step(v, rand_x(), g);
        end

        for (int s = 0; s < 4; s++) step('0, '0, g);
        nvec++;
        if (sb.size() != 0) begin
            nfail++;
            $display("FAIL drain: %0d responses outstanding, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin : p_watchdog
        #2000000;
        nfail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $fatal(1);
    end

endmodule
`default_nettype wire
